// File: rtl/meas_averager.sv
// meas_averager: settles, accumulates 2^L filter samples per channel and publishes sums and averages
module meas_averager #(
  parameter int sig_width    = 12,
  parameter int max_log2_avg = 10,
  localparam int acc_width   = sig_width + max_log2_avg,
  localparam int la_w        = $clog2(max_log2_avg + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [la_w-1:0]      log2_avg,
  input  logic [7:0]           settle,
  input  logic                 filt_done,
  input  logic [sig_width-1:0] filt_in_a,
  input  logic [sig_width-1:0] filt_in_b,
  output logic                 busy,
  output logic                 res_valid,
  input  logic                 res_ack,
  output logic [acc_width-1:0] sum_a,
  output logic [acc_width-1:0] sum_b,
  output logic [sig_width-1:0] avg_a,
  output logic [sig_width-1:0] avg_b,
  output logic                 overrun
);
  localparam int cw = max_log2_avg + 1;
  typedef enum logic [1:0] {IDLE, SETTLE, ACC, FINISH} state_t;
  state_t state, state_n;
  logic [la_w-1:0]      l_q, l_in;
  logic [7:0]           settle_cnt;
  logic [cw-1:0]        cnt, target;
  logic [acc_width-1:0] acc_a, acc_b;
  logic                 last;
  assign l_in   = (log2_avg > la_w'(max_log2_avg)) ? la_w'(max_log2_avg) : log2_avg;
  assign target = (cw'(1) << l_q) - cw'(1);
  assign last   = cnt == target;
  assign busy   = state != IDLE;
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  // next-state logic; abort always returns to IDLE
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = start ? ((settle != 8'd0) ? SETTLE : ACC) : IDLE;
      SETTLE:  state_n = (filt_done && settle_cnt == 8'd1) ? ACC : SETTLE;
      ACC:     state_n = (filt_done && last) ? FINISH : ACC;
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort) state_n = IDLE;
  end
  // datapath: latch parameters, settle countdown, accumulate, commit results
  always_ff @(posedge clk) begin
    if (rst) begin
      l_q        <= '0;
      settle_cnt <= '0;
      cnt        <= '0;
      acc_a      <= '0;
      acc_b      <= '0;
      sum_a      <= '0;
      sum_b      <= '0;
      avg_a      <= '0;
      avg_b      <= '0;
      res_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (abort) begin
        settle_cnt <= '0;
        cnt        <= '0;
        acc_a      <= '0;
        acc_b      <= '0;
      end else if (state == IDLE && start) begin
        l_q        <= l_in;
        settle_cnt <= settle;
        cnt        <= '0;
        acc_a      <= '0;
        acc_b      <= '0;
      end else if (state == SETTLE && filt_done) begin
        settle_cnt <= settle_cnt - 8'd1;
      end else if (state == ACC && filt_done) begin
        acc_a <= acc_a + acc_width'(filt_in_a);
        acc_b <= acc_b + acc_width'(filt_in_b);
        cnt   <= cnt + cw'(1);
      end
      if (state == FINISH) begin
        sum_a     <= acc_a;
        sum_b     <= acc_b;
        avg_a     <= sig_width'(acc_a >> l_q);
        avg_b     <= sig_width'(acc_b >> l_q);
        res_valid <= 1'b1;
      end else if (res_ack) begin
        res_valid <= 1'b0;
      end
      overrun <= abort ? 1'b0 : (state == FINISH && res_valid && !res_ack) ? 1'b1 : overrun;
    end
  end
endmodule

// File: tb/tb_meas_averager.sv
// tb_meas_averager: directed scoreboard bench for meas_averager
module tb_meas_averager;
  logic        clk = 0, rst = 1, start = 0, abort = 0, filt_done = 0, res_ack = 0;
  logic [3:0]  log2_avg = 0;
  logic [7:0]  settle = 0;
  logic [11:0] filt_in_a = 0, filt_in_b = 0;
  logic        busy, res_valid, overrun;
  logic [21:0] sum_a, sum_b;
  logic [11:0] avg_a, avg_b;
  int total = 0, bad = 0;
  typedef struct {int sa; int sb; int aa; int ab;} res_t;
  res_t sb_q[$];

  meas_averager dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .log2_avg(log2_avg),
    .settle(settle), .filt_done(filt_done), .filt_in_a(filt_in_a), .filt_in_b(filt_in_b),
    .busy(busy), .res_valid(res_valid), .res_ack(res_ack), .sum_a(sum_a), .sum_b(sum_b),
    .avg_a(avg_a), .avg_b(avg_b), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic strobe(input int a, input int b);
    filt_done = 1; filt_in_a = 12'(a); filt_in_b = 12'(b);
    tick();
    filt_done = 0;
  endtask

  task automatic do_start(input int lreq, input int s);
    start = 1; log2_avg = 4'(lreq); settle = 8'(s);
    tick();
    start = 0;
  endtask

  task automatic do_meas(input int lreq, input int l_eff, input int s,
                         input int a0, input int da, input int b0, input int db);
    res_t e;
    e.sa = 0; e.sb = 0;
    for (int i = 0; i < (1 << l_eff); i++) begin
      e.sa += a0 + i * da;
      e.sb += b0 + i * db;
    end
    e.aa = e.sa >> l_eff; e.ab = e.sb >> l_eff;
    sb_q.push_back(e);
    do_start(lreq, s);
    for (int i = 0; i < s; i++) strobe(7 + i, 9);
    for (int i = 0; i < (1 << l_eff); i++) strobe(a0 + i * da, b0 + i * db);
  endtask

  task automatic check_result(input string tag);
    res_t e;
    if (sb_q.size() == 0) begin
      total++; bad++;
      $error("FAIL %s_queue got=empty exp=entry", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_sum_a"}, 32'(sum_a), e.sa);
      chk({tag, "_sum_b"}, 32'(sum_b), e.sb);
      chk({tag, "_avg_a"}, 32'(avg_a), e.aa);
      chk({tag, "_avg_b"}, 32'(avg_b), e.ab);
    end
  endtask

  task automatic wait_result(input string tag);
    int n = 0;
    while (busy && n < 3000) begin tick(); n++; end
    chk({tag, "_idle"}, 32'(busy), 0);
    check_result(tag);
    chk({tag, "_valid"}, 32'(res_valid), 1);
  endtask

  task automatic ack();
    res_ack = 1; tick(); res_ack = 0;
  endtask

  initial begin
    tick(); tick();
    rst = 0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(res_valid), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_sum_a", 32'(sum_a), 0);
    chk("rst_sum_b", 32'(sum_b), 0);
    chk("rst_avg_a", 32'(avg_a), 0);
    chk("rst_avg_b", 32'(avg_b), 0);

    do_meas(2, 2, 0, 100, 100, 4095, 0);
    chk("lat_edge1_valid", 32'(res_valid), 0);
    chk("lat_edge1_busy", 32'(busy), 1);
    tick();
    chk("lat_edge2_valid", 32'(res_valid), 1);
    wait_result("l2");
    ack();
    chk("ack_clears", 32'(res_valid), 0);

    strobe(999, 999); strobe(111, 222);
    chk("idle_strobe_busy", 32'(busy), 0);
    chk("idle_strobe_sum", 32'(sum_a), 1000);

    do_meas(0, 0, 3, 55, 0, 66, 0);
    wait_result("settle3_l0");
    ack();

    do_meas(10, 10, 0, 4095, 0, 4095, 0);
    wait_result("l10");
    ack();
    do_meas(15, 10, 0, 4095, 0, 4095, 0);
    wait_result("l15_clamp");
    ack();

    do_meas(1, 1, 0, 10, 5, 20, 1);
    wait_result("ovr1");
    chk("ovr1_flag", 32'(overrun), 0);
    do_meas(1, 1, 2, 300, 1, 40, 2);
    wait_result("ovr2");
    chk("ovr2_flag", 32'(overrun), 1);
    do_meas(0, 0, 0, 77, 0, 88, 0);
    res_ack = 1; tick(); res_ack = 0;
    check_result("ack_finish");
    chk("ack_finish_valid", 32'(res_valid), 1);
    chk("ack_finish_ovr", 32'(overrun), 1);
    ack();
    chk("ack_keeps_ovr", 32'(overrun), 1);
    abort = 1; tick(); abort = 0;
    chk("abort_clr_ovr", 32'(overrun), 0);

    do_start(2, 0);
    strobe(500, 600); strobe(501, 601);
    abort = 1; tick(); abort = 0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_valid", 32'(res_valid), 0);
    chk("abort_sum_a", 32'(sum_a), 77);
    sb_q.push_back('{sa: 40, sb: 60, aa: 20, ab: 30});
    do_start(1, 0);
    strobe(10, 20);
    start = 1; log2_avg = 0; settle = 5; tick(); start = 0;
    chk("start_ignored_busy", 32'(busy), 1);
    strobe(30, 40);
    wait_result("restart");

    do_start(2, 0);
    strobe(1000, 1000); strobe(1000, 1000);
    rst = 1; tick(); rst = 0;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_valid", 32'(res_valid), 0);
    chk("mid_rst_sum_a", 32'(sum_a), 0);
    chk("mid_rst_avg_b", 32'(avg_b), 0);
    strobe(1000, 1000); strobe(1000, 1000); tick();
    chk("post_rst_valid", 32'(res_valid), 0);
    chk("post_rst_busy", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
